vga_char_scheduler: RTL

//  Shares the single-character write port (VData/Wen) of the VGA text controller between NREQ

---
 rtl/vga_sched_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/vga_char_scheduler.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_sched_pkg.sv
// Shared types and character codes for the VGA character write scheduler.
package vga_sched_pkg;

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    ISSUE,
    GAP,
    LINECLR
  } sched_state_e;

  localparam logic [7:0] CH_BS   = 8'h08;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_PMIN = 8'h20;
  localparam logic [7:0] CH_PMAX = 8'h7D;

  // Characters the text controller understands; everything else is dropped at pop.
  function automatic logic is_issuable(input logic [7:0] ch);
    return (ch == CH_BS) || (ch == CH_LF) || ((ch >= CH_PMIN) && (ch <= CH_PMAX));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers; head is the oldest entry (valid when !empty).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/vga_char_scheduler.sv
// Round-robin merge of several character producers into one paced VData/Wen stream
// with idle spacing for backspace completion and new-line blanking.
module vga_char_scheduler
  import vga_sched_pkg::*;
#(
  parameter int NREQ            = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int COL             = 80,
  parameter int GAP_CYCLES      = 2,
  parameter int LINE_CLR_CYCLES = 84
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              vga_init,
  output logic [7:0]        vdata,
  output logic              wen,
  output logic              busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(LINE_CLR_CYCLES + 1);
  localparam int COL_W = (COL > 1) ? $clog2(COL) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] grant_idx, cand;
  logic             found;
  logic [7:0]       push_data;
  logic             push, pop;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_head;

  sched_state_e     state_q, state_d;
  logic             wen_q, wen_d;
  logic [7:0]       vdata_q, vdata_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap;

  // Grant the first valid requester after the last accepted one; nothing while full.
  always_comb begin
    found     = 1'b0;
    grant_idx = rr_ptr_q;
    cand      = '0;
    if (!fifo_full) begin
      for (int k = 1; k <= NREQ; k++) begin
        cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
        for (int i = 0; i < NREQ; i++) begin
          if (!found && req_valid[i] && (cand == PTR_W'(i))) begin
            found     = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
    req_ready = '0;
    push_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        req_ready[i] = found;
        push_data    = req_data[8*i +: 8];
      end
    end
    push     = found;
    rr_ptr_d = found ? grant_idx : rr_ptr_q;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  always_comb begin
    state_d = state_q;
    wen_d   = 1'b0;
    vdata_d = vdata_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      WAIT_INIT: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (is_issuable(fifo_head)) begin
            state_d = ISSUE;
            wen_d   = 1'b1;
            vdata_d = fifo_head;
          end
        end
      end
      ISSUE: begin
        if (vdata_q == CH_LF) begin
          col_d = '0;
          wrap  = 1'b1;
        end else if (vdata_q == CH_BS) begin
          if (col_q != '0) col_d = col_q - 1'b1;
        end else if (({1'b0, col_q} + 1'b1) == (COL_W+1)'(COL)) begin
          col_d = '0;
          wrap  = 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        if (wrap) begin
          state_d = LINECLR;
          cnt_d   = CNT_W'(LINE_CLR_CYCLES - 1);
        end else begin
          state_d = GAP;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end
      end
      GAP, LINECLR: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = WAIT_INIT;
    endcase
    // Losing init overrides everything; queued characters stay in the FIFO.
    if (!vga_init) begin
      state_d = WAIT_INIT;
      wen_d   = 1'b0;
      vdata_d = vdata_q;
      pop     = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= WAIT_INIT;
      wen_q    <= 1'b0;
      vdata_q  <= '0;
      col_q    <= '0;
      cnt_q    <= '0;
      rr_ptr_q <= PTR_W'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      wen_q    <= wen_d;
      vdata_q  <= vdata_d;
      col_q    <= col_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign wen   = wen_q;
  assign vdata = vdata_q;
  assign busy  = !fifo_empty || ((state_q != IDLE) && (state_q != WAIT_INIT));

endmodule
